// File: rtl/mdio_receptor_param.sv
// Clause-22 MDIO slave (PHY side): oversamples MDC on CLK, decodes frames, strobes the register bank and serialises read data.
// Strobes and MDIO_IN are registered one CLK after the decoding sample event; the generator paces everything, no backpressure.
module mdio_receptor_param #(
    parameter int unsigned PHY_ADDR   = 1,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned BCAST_EN   = 1
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  MDC,
    input  logic                  MDIO_OUT,
    input  logic                  MDIO_OE,
    input  logic [DATA_WIDTH-1:0] RD_DATA,
    output logic                  MDIO_IN,
    output logic                  MDIO_DONE,
    output logic [ADDR_WIDTH-1:0] ADDR,
    output logic [ADDR_WIDTH-1:0] REGADR,
    output logic [DATA_WIDTH-1:0] WR_DATA,
    output logic                  WR_STB,
    output logic                  RD_STB,
    output logic                  FRAME_ERR
);

    localparam int unsigned FRAME_LEN = 6 + 2 * ADDR_WIDTH + DATA_WIDTH;
    localparam int unsigned CW        = $clog2(FRAME_LEN);
    localparam int unsigned SW        = (DATA_WIDTH > ADDR_WIDTH) ? DATA_WIDTH : ADDR_WIDTH;
    localparam logic [CW-1:0] A_LAST  = CW'(ADDR_WIDTH - 1);
    localparam logic [CW-1:0] D_LAST  = CW'(DATA_WIDTH - 1);
    localparam logic [ADDR_WIDTH-1:0] MY_ADDR = ADDR_WIDTH'(PHY_ADDR);

    typedef enum logic [3:0] {
        S_IDLE, S_ST2, S_OP, S_PHYAD, S_REGAD, S_WTA, S_WDATA, S_RTA, S_RDATA
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;

    logic            mdc_s1, mdc_s2, mdc_d;
    logic            out_s1, out_s2, oe_s1, oe_s2;
    logic            sample;

    logic [SW-2:0]   rx;
    logic [SW-1:0]   rx_in;
    logic [DATA_WIDTH-1:0] tx;
    logic            op_wr, match_r, rd_cap;

    logic            err_set, wr_set, rd_set, done_set;
    logic            shift_en, op_ld, ld_addr, ld_reg, tx_out, tx_zero;

    // MDIO data travels through the same two-flop delay as MDC so it lines up with the detected edge
    assign sample = mdc_s2 & ~mdc_d;
    assign rx_in  = {rx, out_s2};

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        err_set   = 1'b0;
        wr_set    = 1'b0;
        rd_set    = 1'b0;
        done_set  = 1'b0;
        shift_en  = 1'b0;
        op_ld     = 1'b0;
        ld_addr   = 1'b0;
        ld_reg    = 1'b0;
        tx_out    = 1'b0;
        tx_zero   = 1'b0;
        if (sample) begin
            case (state)
                S_IDLE: begin
                    if (oe_s2 && !out_s2) begin
                        state_nxt = S_ST2;
                        cnt_nxt   = '0;
                    end
                end
                S_ST2: begin
                    if (!oe_s2 || !out_s2) err_set = 1'b1;
                    else state_nxt = S_OP;
                end
                S_OP: begin
                    if (!oe_s2) begin
                        err_set = 1'b1;
                    end else if (cnt == '0) begin
                        shift_en = 1'b1;
                        cnt_nxt  = cnt + 1'b1;
                    end else if (rx[0] != out_s2) begin
                        op_ld     = 1'b1;
                        state_nxt = S_PHYAD;
                        cnt_nxt   = '0;
                    end else begin
                        err_set = 1'b1;
                    end
                end
                S_PHYAD: begin
                    if (!oe_s2) begin
                        err_set = 1'b1;
                    end else begin
                        shift_en = 1'b1;
                        if (cnt == A_LAST) begin
                            ld_addr   = 1'b1;
                            state_nxt = S_REGAD;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = cnt + 1'b1;
                        end
                    end
                end
                S_REGAD: begin
                    if (!oe_s2) begin
                        err_set = 1'b1;
                    end else begin
                        shift_en = 1'b1;
                        if (cnt == A_LAST) begin
                            ld_reg    = 1'b1;
                            cnt_nxt   = '0;
                            if (op_wr) begin
                                state_nxt = S_WTA;
                            end else begin
                                state_nxt = S_RTA;
                                rd_set    = match_r;
                            end
                        end else begin
                            cnt_nxt = cnt + 1'b1;
                        end
                    end
                end
                S_WTA: begin
                    if (!oe_s2 || (out_s2 != (cnt == '0))) begin
                        err_set = 1'b1;
                    end else if (cnt == '0) begin
                        cnt_nxt = cnt + 1'b1;
                    end else begin
                        state_nxt = S_WDATA;
                        cnt_nxt   = '0;
                    end
                end
                S_WDATA: begin
                    if (!oe_s2) begin
                        err_set = 1'b1;
                    end else begin
                        shift_en = 1'b1;
                        if (cnt == D_LAST) begin
                            wr_set    = match_r;
                            done_set  = match_r;
                            state_nxt = S_IDLE;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = cnt + 1'b1;
                        end
                    end
                end
                // Generator has released the line: OE is not checked on the read turnaround and data
                S_RTA: begin
                    if (cnt == '0) begin
                        cnt_nxt = cnt + 1'b1;
                    end else begin
                        tx_out    = 1'b1;
                        state_nxt = S_RDATA;
                        cnt_nxt   = '0;
                    end
                end
                S_RDATA: begin
                    if (cnt == D_LAST) begin
                        tx_zero   = 1'b1;
                        done_set  = match_r;
                        state_nxt = S_IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        tx_out  = 1'b1;
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end
            endcase
            if (err_set) begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            mdc_s1    <= 1'b0;
            mdc_s2    <= 1'b0;
            mdc_d     <= 1'b0;
            out_s1    <= 1'b0;
            out_s2    <= 1'b0;
            oe_s1     <= 1'b0;
            oe_s2     <= 1'b0;
            rx        <= '0;
            tx        <= '0;
            op_wr     <= 1'b0;
            match_r   <= 1'b0;
            rd_cap    <= 1'b0;
            MDIO_IN   <= 1'b0;
            MDIO_DONE <= 1'b0;
            ADDR      <= '0;
            REGADR    <= '0;
            WR_DATA   <= '0;
            WR_STB    <= 1'b0;
            RD_STB    <= 1'b0;
            FRAME_ERR <= 1'b0;
        end else begin
            mdc_s1    <= MDC;
            mdc_s2    <= mdc_s1;
            mdc_d     <= mdc_s2;
            out_s1    <= MDIO_OUT;
            out_s2    <= out_s1;
            oe_s1     <= MDIO_OE;
            oe_s2     <= oe_s1;

            WR_STB    <= wr_set;
            RD_STB    <= rd_set;
            MDIO_DONE <= done_set;
            FRAME_ERR <= err_set;
            rd_cap    <= RD_STB;

            if (shift_en) rx <= rx_in[SW-2:0];
            if (op_ld)    op_wr <= out_s2;
            if (ld_addr) begin
                ADDR    <= rx_in[ADDR_WIDTH-1:0];
                match_r <= (rx_in[ADDR_WIDTH-1:0] == MY_ADDR) ||
                           ((BCAST_EN != 0) && op_wr && (rx_in[ADDR_WIDTH-1:0] == '0));
            end
            if (ld_reg) REGADR  <= rx_in[ADDR_WIDTH-1:0];
            if (wr_set) WR_DATA <= rx_in[DATA_WIDTH-1:0];

            // Unmatched reads still walk the shifter but keep MDIO_IN low
            if (tx_out) begin
                MDIO_IN <= match_r & tx[DATA_WIDTH-1];
                tx      <= {tx[DATA_WIDTH-2:0], 1'b0};
            end else if (tx_zero) begin
                MDIO_IN <= 1'b0;
            end
            // Bank data is valid the CLK after RD_STB; TA is far enough away that this never meets a shift
            if (rd_cap) tx <= RD_DATA;
        end
    end

endmodule

// File: tb/tb_mdio_receptor_param.sv
// Directed, table-driven bench for mdio_receptor_param at DATA_WIDTH 16 and 32.
module tb_mdio_receptor_param;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic RESET, MDC, mdio_out, oe, sel32;
    logic oe16, oe32;
    logic [15:0] rd16;
    logic [31:0] rd32;
    assign oe16 = oe & ~sel32;
    assign oe32 = oe & sel32;

    logic        in16, done16, wr16, rs16, err16;
    logic [4:0]  addr16, reg16;
    logic [15:0] wd16;
    logic        in32, done32, wr32, rs32, err32;
    logic [4:0]  addr32, reg32;
    logic [31:0] wd32;

    mdio_receptor_param #(.PHY_ADDR(1), .ADDR_WIDTH(5), .DATA_WIDTH(16), .BCAST_EN(1)) dut16 (
        .CLK(CLK), .RESET(RESET), .MDC(MDC), .MDIO_OUT(mdio_out), .MDIO_OE(oe16),
        .RD_DATA(rd16), .MDIO_IN(in16), .MDIO_DONE(done16), .ADDR(addr16), .REGADR(reg16),
        .WR_DATA(wd16), .WR_STB(wr16), .RD_STB(rs16), .FRAME_ERR(err16));

    mdio_receptor_param #(.PHY_ADDR(1), .ADDR_WIDTH(5), .DATA_WIDTH(32), .BCAST_EN(1)) dut32 (
        .CLK(CLK), .RESET(RESET), .MDC(MDC), .MDIO_OUT(mdio_out), .MDIO_OE(oe32),
        .RD_DATA(rd32), .MDIO_IN(in32), .MDIO_DONE(done32), .ADDR(addr32), .REGADR(reg32),
        .WR_DATA(wd32), .WR_STB(wr32), .RD_STB(rs32), .FRAME_ERR(err32));

    logic        s_in, s_done, s_wr, s_rd, s_err;
    logic [4:0]  s_addr, s_reg;
    logic [31:0] s_wdata;
    always_comb begin
        s_in    = sel32 ? in32   : in16;
        s_done  = sel32 ? done32 : done16;
        s_wr    = sel32 ? wr32   : wr16;
        s_rd    = sel32 ? rs32   : rs16;
        s_err   = sel32 ? err32  : err16;
        s_addr  = sel32 ? addr32 : addr16;
        s_reg   = sel32 ? reg32  : reg16;
        s_wdata = sel32 ? wd32   : {16'h0, wd16};
    end

    int n_wr = 0, n_rd = 0, n_done = 0, n_err = 0, n_wr_nd = 0;
    logic [31:0] cap_wdata = '0;
    always @(negedge CLK) begin
        if (s_wr) begin
            n_wr++;
            cap_wdata = s_wdata;
            if (!s_done) n_wr_nd++;
        end
        if (s_rd)   n_rd++;
        if (s_done) n_done++;
        if (s_err)  n_err++;
    end

    int n_cmp = 0, n_mis = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        sel32;
        int          half;
        logic [1:0]  st, op;
        logic [4:0]  phy, rg;
        logic [1:0]  ta;
        logic [31:0] data;
        int          drop_at, rst_at;
        int          e_wr, e_rd, e_done, e_err;
        logic        chk_addr;
        logic [31:0] e_rbits;
    } vec_t;

    function automatic vec_t mk(logic s32, int h, logic [1:0] st, logic [1:0] op, logic [4:0] phy,
                                logic [4:0] rg, logic [1:0] ta, logic [31:0] d, int drop, int rst,
                                int ew, int er, int ed, int ee, logic ca, logic [31:0] rb);
        vec_t v;
        v.sel32 = s32; v.half = h; v.st = st; v.op = op; v.phy = phy; v.rg = rg; v.ta = ta;
        v.data = d; v.drop_at = drop; v.rst_at = rst; v.e_wr = ew; v.e_rd = er; v.e_done = ed;
        v.e_err = ee; v.chk_addr = ca; v.e_rbits = rb;
        return v;
    endfunction

    function automatic logic frame_bit(vec_t v, int i, int dw);
        if (i < 2)  return v.st[1-i];
        if (i < 4)  return v.op[3-i];
        if (i < 9)  return v.phy[8-i];
        if (i < 14) return v.rg[13-i];
        if (i < 16) return v.ta[15-i];
        return v.data[dw-1-(i-16)];
    endfunction

    task automatic clk_wait(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    logic [31:0] rbits;

    task automatic check_zero(input string tag);
        chk({tag, "_in"},   {31'h0, s_in},   32'h0);
        chk({tag, "_done"}, {31'h0, s_done}, 32'h0);
        chk({tag, "_wr"},   {31'h0, s_wr},   32'h0);
        chk({tag, "_rd"},   {31'h0, s_rd},   32'h0);
        chk({tag, "_err"},  {31'h0, s_err},  32'h0);
        chk({tag, "_addr"}, {27'h0, s_addr}, 32'h0);
        chk({tag, "_reg"},  {27'h0, s_reg},  32'h0);
        chk({tag, "_wdat"}, s_wdata,         32'h0);
    endtask

    task automatic send(input vec_t v);
        int   dw;
        int   len;
        logic rd;
        logic stop;
        dw   = v.sel32 ? 32 : 16;
        len  = 16 + dw;
        rd   = (v.op == 2'b10);
        stop = 1'b0;
        rbits = '0;
        for (int p = 0; p < 32; p++) begin
            MDC = 1'b0; mdio_out = 1'b1; oe = 1'b1;
            clk_wait(v.half);
            MDC = 1'b1;
            clk_wait(v.half);
        end
        for (int i = 0; i < len && !stop; i++) begin
            logic e;
            e = (i < v.drop_at) && !(rd && i >= 14);
            MDC = 1'b0;
            mdio_out = e ? frame_bit(v, i, dw) : 1'b0;
            oe = e;
            if (i == v.rst_at) begin
                RESET = 1'b0;
                #1;
                check_zero("midrst");
                clk_wait(3);
                oe = 1'b0;
                RESET = 1'b1;
                stop = 1'b1;
            end else begin
                clk_wait(v.half);
                if (i >= 16) rbits[dw-1-(i-16)] = s_in;
                MDC = 1'b1;
                clk_wait(v.half);
            end
        end
        MDC = 1'b0; oe = 1'b0; mdio_out = 1'b0;
    endtask

    localparam int NV = 19;
    vec_t tv [NV];

    initial begin
        tv[0]  = mk(0, 2,  2'b01, 2'b01, 5'd1, 5'd3, 2'b10, 32'hA5C3,     99, -1, 1, 0, 1, 0, 1, 32'h0);
        tv[1]  = mk(0, 2,  2'b01, 2'b10, 5'd1, 5'd2, 2'b10, 32'hBEEF,     99, -1, 0, 1, 1, 0, 1, 32'hBEEF);
        tv[2]  = mk(0, 2,  2'b01, 2'b01, 5'd5, 5'd7, 2'b10, 32'h1234,     99, -1, 0, 0, 0, 0, 1, 32'h0);
        tv[3]  = mk(0, 2,  2'b01, 2'b01, 5'd1, 5'd4, 2'b10, 32'h5A5A,     99, -1, 1, 0, 1, 0, 1, 32'h0);
        tv[4]  = mk(0, 2,  2'b01, 2'b01, 5'd0, 5'd9, 2'b10, 32'h0F0F,     99, -1, 1, 0, 1, 0, 1, 32'h0);
        tv[5]  = mk(0, 2,  2'b01, 2'b10, 5'd0, 5'd2, 2'b10, 32'hBEEF,     99, -1, 0, 0, 0, 0, 1, 32'h0);
        tv[6]  = mk(0, 2,  2'b01, 2'b11, 5'd1, 5'd3, 2'b10, 32'h1111,      4, -1, 0, 0, 0, 1, 0, 32'h0);
        tv[7]  = mk(0, 2,  2'b01, 2'b01, 5'd1, 5'd3, 2'b11, 32'h2222,     16, -1, 0, 0, 0, 1, 0, 32'h0);
        tv[8]  = mk(0, 2,  2'b01, 2'b01, 5'd1, 5'd3, 2'b10, 32'h3333,      6, -1, 0, 0, 0, 1, 0, 32'h0);
        tv[9]  = mk(0, 2,  2'b01, 2'b00, 5'd1, 5'd3, 2'b10, 32'h4444,      4, -1, 0, 0, 0, 1, 0, 32'h0);
        tv[10] = mk(0, 2,  2'b00, 2'b01, 5'd1, 5'd3, 2'b10, 32'h5555,      2, -1, 0, 0, 0, 1, 0, 32'h0);
        tv[11] = mk(0, 2,  2'b01, 2'b01, 5'd1, 5'd3, 2'b10, 32'hFFFF,     99, 24, 0, 0, 0, 0, 0, 32'h0);
        tv[12] = mk(0, 10, 2'b01, 2'b01, 5'd1, 5'd3, 2'b10, 32'hA5C3,     99, -1, 1, 0, 1, 0, 1, 32'h0);
        tv[13] = mk(0, 10, 2'b01, 2'b10, 5'd1, 5'd2, 2'b10, 32'hBEEF,     99, -1, 0, 1, 1, 0, 1, 32'hBEEF);
        tv[14] = mk(1, 2,  2'b01, 2'b01, 5'd1, 5'd3, 2'b10, 32'hDEADBEEF, 99, -1, 1, 0, 1, 0, 1, 32'h0);
        tv[15] = mk(1, 2,  2'b01, 2'b10, 5'd1, 5'd2, 2'b10, 32'h89ABCDEF, 99, -1, 0, 1, 1, 0, 1, 32'h89ABCDEF);
        tv[16] = mk(1, 10, 2'b01, 2'b01, 5'd1, 5'd3, 2'b10, 32'hDEADBEEF, 99, -1, 1, 0, 1, 0, 1, 32'h0);
        tv[17] = mk(1, 10, 2'b01, 2'b10, 5'd1, 5'd2, 2'b10, 32'h89ABCDEF, 99, -1, 0, 1, 1, 0, 1, 32'h89ABCDEF);
        tv[18] = mk(1, 2,  2'b01, 2'b01, 5'd5, 5'd6, 2'b10, 32'hCAFEF00D, 99, -1, 0, 0, 0, 0, 1, 32'h0);

        RESET = 1'b0; MDC = 1'b0; mdio_out = 1'b0; oe = 1'b0; sel32 = 1'b0;
        rd16 = '0; rd32 = '0;
        clk_wait(5);
        @(negedge CLK);
        check_zero("por16");
        sel32 = 1'b1;
        #1;
        check_zero("por32");
        sel32 = 1'b0;
        clk_wait(1);
        RESET = 1'b1;
        clk_wait(3);

        for (int k = 0; k < NV; k++) begin
            int b_wr, b_rd, b_done, b_err, b_nd;
            sel32 = tv[k].sel32;
            rd16  = tv[k].data[15:0];
            rd32  = tv[k].data;
            clk_wait(4);
            b_wr = n_wr; b_rd = n_rd; b_done = n_done; b_err = n_err; b_nd = n_wr_nd;
            send(tv[k]);
            clk_wait(12);
            @(negedge CLK);
            chk($sformatf("v%0d_wr_stb", k),    32'(n_wr - b_wr),     32'(tv[k].e_wr));
            chk($sformatf("v%0d_rd_stb", k),    32'(n_rd - b_rd),     32'(tv[k].e_rd));
            chk($sformatf("v%0d_done", k),      32'(n_done - b_done), 32'(tv[k].e_done));
            chk($sformatf("v%0d_frame_err", k), 32'(n_err - b_err),   32'(tv[k].e_err));
            chk($sformatf("v%0d_wr_wo_done", k), 32'(n_wr_nd - b_nd), 32'h0);
            chk($sformatf("v%0d_mdio_in_idle", k), {31'h0, s_in},     32'h0);
            if (tv[k].e_wr != 0)
                chk($sformatf("v%0d_wr_data", k), cap_wdata, tv[k].data);
            if (tv[k].chk_addr) begin
                chk($sformatf("v%0d_addr", k),   {27'h0, s_addr}, {27'h0, tv[k].phy});
                chk($sformatf("v%0d_regadr", k), {27'h0, s_reg},  {27'h0, tv[k].rg});
            end
            if (tv[k].op == 2'b10 && tv[k].drop_at > 16)
                chk($sformatf("v%0d_rd_bits", k), rbits, tv[k].e_rbits);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/mdio_receptor_param.md
Name: mdio_receptor_param

Overview:
- Parametrised, CLK-synchronous successor to the MDIO receptor: the PHY-side slave for Clause-22 MDIO frames.
- Oversamples MDC in the CLK domain and decodes ST/OP/PHYAD/REGAD/TA/DATA from MDIO_OUT/MDIO_OE (driven by the generator).
- Issues register write strobes and read requests to the register bank, and returns read data on MDIO_IN.
- Adds configurable PHY address match, broadcast writes, data width, and frame-error reporting.

Parameters:
- PHY_ADDR, 5'd1, PHY address this slave responds to.
- ADDR_WIDTH, 5, width of the PHYAD and REGAD fields.
- DATA_WIDTH, 16, width of the data field.
- BCAST_EN, 1, when 1 a write with PHYAD=0 is accepted as broadcast; reads to 0 are never answered.

Ports:
- CLK  in  1  system clock; all logic on posedge.
- RESET  in  1  asynchronous, active-low reset.
- MDC  in  1  management clock from the generator; max frequency CLK/4.
- MDIO_OUT  in  1  serial data from the generator.
- MDIO_OE  in  1  generator drive enable; 1 = MDIO_OUT is valid.
- RD_DATA  in  DATA_WIDTH  register-bank read data; valid the CLK after RD_STB.
- MDIO_IN  out  1  serial read data back to the generator, MSB first.
- MDIO_DONE  out  1  one-CLK pulse when an addressed frame completes.
- ADDR  out  ADDR_WIDTH  latched PHYAD of the current/last frame.
- REGADR  out  ADDR_WIDTH  latched REGAD of the current/last frame.
- WR_DATA  out  DATA_WIDTH  latched write data.
- WR_STB  out  1  one-CLK write strobe.
- RD_STB  out  1  one-CLK read request.
- FRAME_ERR  out  1  one-CLK pulse on a malformed frame.

Behaviour:
- Reset: all outputs are 0, state is IDLE, the bit counter is 0, and the shift registers are 0. Reset has immediate effect, including mid-frame; the frame in progress is discarded and no strobes fire.
- MDC synchroniser:
  - Two-flop synchroniser plus an edge register.
  - A "sample event" is one CLK where the synchronised MDC rises.
  - MDIO_OUT and MDIO_OE pass through the same two-flop delay and are sampled only on sample events.
- Frame length: 2+2+2*ADDR_WIDTH+2+DATA_WIDTH bits (32 by default).
- IDLE:
  - On a sample event with OE=1 and OUT=0, go to ST2 (first start bit).
  - OE=1 with OUT=1 is preamble and is ignored.
- ST2: bit must be 1, otherwise FRAME_ERR and go to IDLE.
- OP: shift 2 bits.
  - 10 = read, 01 = write.
  - 00 or 11: FRAME_ERR after the second bit, then go to IDLE.
- PHYAD, then REGAD: shift ADDR_WIDTH bits each, MSB first.
  - ADDR is loaded at the end of PHYAD; REGADR at the end of REGAD.
  - match = (PHYAD==PHY_ADDR) | (BCAST_EN & PHYAD==0 & op==write).
- Write path:
  - TA: 2 bits, must be 1,0, otherwise FRAME_ERR and go to IDLE.
  - DATA: shift DATA_WIDTH bits.
  - On the CLK after the last sample event, if match: WR_DATA is loaded, WR_STB=1 and MDIO_DONE=1 for exactly one CLK.
  - Unmatched: the bits are consumed silently with no pulses.
  - Return to IDLE.
- Read path:
  - The CLK after the REGAD end, if match: RD_STB=1 for one CLK; RD_DATA is captured into the tx shifter on the following CLK.
  - TA: 2 sample events; OE is ignored.
  - On the second TA sample event, MDIO_IN = tx[MSB].
  - Each subsequent sample event shifts: MDIO_IN = next bit.
  - After DATA_WIDTH data sample events: MDIO_IN=0 and MDIO_DONE pulses for one CLK, then go to IDLE.
  - Unmatched: MDIO_IN stays 0, no RD_STB/DONE, the frame is still counted out.
- OE deasserted:
  - During ST2..REGAD, or during write TA/DATA: FRAME_ERR and go to IDLE.
  - During read TA/DATA: legal.
- Once a frame has started, IDLE is entered only via completion, error, or reset.
- Counter: width is clog2 of the frame length. It resets to 0 on every phase change and never wraps inside a phase.
- WR_STB and RD_STB are never asserted in the same CLK. FRAME_ERR and MDIO_DONE are mutually exclusive.

Test Plan:
- Write to PHY 1 (PHY_ADDR=1): preamble 32×'1', ST 01, OP 01, PHYAD 00001, REGAD 00011, TA 10, data 16'hA5C3 -> one WR_STB with ADDR=1, REGADR=3, WR_DATA=16'hA5C3; MDIO_DONE in the same CLK.
- Read from PHY 1, REGAD 2, with RD_DATA=16'hBEEF -> RD_STB pulse after REGAD; MDIO_IN serialises 1011111011101111 on successive MDC edges; MDIO_DONE after the 16th bit.
- Write to PHYAD 5 -> no WR_STB/DONE/FRAME_ERR; a following valid frame to PHY 1 is accepted normally. Write to PHYAD 0 with BCAST_EN=1 -> WR_STB; read to PHYAD 0 -> no RD_STB.
- OP=11 -> FRAME_ERR pulse after the second OP bit, no strobes. Write with TA=11 -> FRAME_ERR. OE dropped during PHYAD -> FRAME_ERR.
- RESET asserted at data bit 8 of a write -> all outputs are 0 immediately, no WR_STB; a full frame after release decodes correctly.
- Rerun the write/read tests at DATA_WIDTH=32, ADDR_WIDTH=5, and at MDC=CLK/4 vs CLK/20 -> identical decoded values.
